dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with lock ownership and 1-cycle reads
// Optional round-robin tie-break on simultaneous requests: define DMEM_ARB_RR_EN.
module dmem_arbiter #(
  parameter int PC_BITS  = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               req0_i,
  input  logic               req1_i,
  input  logic               we0_i,
  input  logic               we1_i,
  input  logic               lock0_i,
  input  logic               lock1_i,
  input  logic [PC_BITS-1:0] addr0_i,
  input  logic [PC_BITS-1:0] addr1_i,
  input  logic [PC_BITS-1:0] wdata0_i,
  input  logic [PC_BITS-1:0] wdata1_i,
  output logic               gnt0_o,
  output logic               gnt1_o,
  output logic               rvalid0_o,
  output logic               rvalid1_o,
  output logic [PC_BITS-1:0] rdata0_o,
  output logic [PC_BITS-1:0] rdata1_o,
  output logic               mem_en_o,
  output logic               mem_we_o,
  output logic [PC_BITS-1:0] mem_addr_o,
  output logic [PC_BITS-1:0] mem_wdata_o,
  input  logic [PC_BITS-1:0] mem_rdata_i
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_next;
  logic [CW-1:0] lock_cnt;
  logic          gnt0, gnt1;

`ifdef DMEM_ARB_RR_EN
  logic last_gnt;  // 1 = port 1 was granted most recently

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_gnt <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last_gnt <= gnt1;
    end
  end
`endif

  always_comb begin
    state_next = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    if (rst_n_i) begin
      case (state)
        IDLE: begin
          if (req0_i && req1_i) begin
`ifdef DMEM_ARB_RR_EN
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
`else
            gnt0 = 1'b1;
`endif
          end else begin
            gnt0 = req0_i;
            gnt1 = req1_i;
          end
          if (gnt0 && lock0_i) begin
            state_next = OWN0;
          end else if (gnt1 && lock1_i) begin
            state_next = OWN1;
          end
        end
        OWN0: begin
          gnt0 = req0_i;
          if ((gnt0 && !lock0_i) || lock_cnt == CNT_LAST) begin
            state_next = IDLE;
          end
        end
        OWN1: begin
          gnt1 = req1_i;
          if ((gnt1 && !lock1_i) || lock_cnt == CNT_LAST) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign gnt0_o      = gnt0;
  assign gnt1_o      = gnt1;
  assign mem_en_o    = gnt0 || gnt1;
  assign mem_we_o    = gnt0 ? we0_i    : (gnt1 ? we1_i    : 1'b0);
  assign mem_addr_o  = gnt0 ? addr0_i  : (gnt1 ? addr1_i  : '0);
  assign mem_wdata_o = gnt0 ? wdata0_i : (gnt1 ? wdata1_i : '0);

  // Ownership is only entered from IDLE, so holding the counter at zero there clears it on entry.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      lock_cnt  <= '0;
      rvalid0_o <= 1'b0;
      rvalid1_o <= 1'b0;
      rdata0_o  <= '0;
      rdata1_o  <= '0;
    end else begin
      state     <= state_next;
      lock_cnt  <= (state == IDLE) ? '0 : lock_cnt + CW'(1);
      rvalid0_o <= gnt0 && !we0_i;
      rvalid1_o <= gnt1 && !we1_i;
      if (gnt0 && !we0_i) begin
        rdata0_o <= mem_rdata_i;
      end
      if (gnt1 && !we1_i) begin
        rdata1_o <= mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    int          port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } gexp_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq0[$];
  rexp_t rq1[$];

  dmem_arbiter #(.PC_BITS(16), .LOCK_MAX(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .lock0_i(lock0), .lock1_i(lock1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata0_o(rdata0), .rdata1_o(rdata1),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  assign mem_rdata = mem_model(mem_addr);

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows a grant or read data.
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
    if (gnt0 || gnt1) begin
      if (gq.size() == 0) begin
        chk("unexpected_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      end else begin
        g = gq.pop_front();
        chk("gnt_cycle", cyc, g.cyc);
        chk("gnt_port", {30'd0, gnt1, gnt0}, (g.port == 0) ? 32'd1 : 32'd2);
        chk("mem_en", {31'd0, mem_en}, 32'd1);
        chk("mem_we", {31'd0, mem_we}, {31'd0, g.we});
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, g.addr});
        chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, g.wdata});
      end
    end else begin
      chk("idle_mem_outputs", {mem_en, mem_we, mem_addr, mem_wdata[13:0]}, 32'd0);
    end
    if (rvalid0) begin
      if (rq0.size() == 0) begin
        chk("unexpected_rvalid0", 32'd1, 32'd0);
      end else begin
        r = rq0.pop_front();
        chk("rvalid0_cycle", cyc, r.cyc);
        chk("rdata0", {16'd0, rdata0}, {16'd0, r.data});
      end
    end
    if (rvalid1) begin
      if (rq1.size() == 0) begin
        chk("unexpected_rvalid1", 32'd1, 32'd0);
      end else begin
        r = rq1.pop_front();
        chk("rvalid1_cycle", cyc, r.cyc);
        chk("rdata1", {16'd0, rdata1}, {16'd0, r.data});
      end
    end
  end

  task automatic set0(input logic r, input logic w, input logic l, input logic [15:0] a, input logic [15:0] d);
    req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic l, input logic [15:0] a, input logic [15:0] d);
    req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
  endtask

  // Runs one cycle with the current inputs; exp is the port expected to be granted (-1 = none).
  task automatic step(input int exp);
    gexp_t g;
    rexp_t r;
    if (exp == 0) begin
      g = '{cyc: cyc, port: 0, we: we0, addr: addr0, wdata: wdata0};
      gq.push_back(g);
      if (!we0) begin
        r = '{cyc: cyc + 1, data: mem_model(addr0)};
        rq0.push_back(r);
      end
    end else if (exp == 1) begin
      g = '{cyc: cyc, port: 1, we: we1, addr: addr1, wdata: wdata1};
      gq.push_back(g);
      if (!we1) begin
        r = '{cyc: cyc + 1, data: mem_model(addr1)};
        rq1.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set0(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    set1(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0055);
    step(-1);
    step(-1);
    chk("reset_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    chk("reset_rdata", {rdata1, rdata0}, 32'd0);

    // Single read by port 0 returns 0xBEEF one cycle later
    rst_n = 1'b1;
    set0(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    set1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(0);
    set0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(-1);

    set1(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    step(1);

    // Both requesting without lock; last grant went to port 1
    for (int i = 0; i < 4; i++) begin
      set0(1'b1, 1'b0, 1'b0, 16'h0100 + 16'(i), 16'h0000);
      set1(1'b1, 1'b0, 1'b0, 16'h0200 + 16'(i), 16'h0000);
`ifdef DMEM_ARB_RR_EN
      step(i % 2);
`else
      step(0);
`endif
    end
    set1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Back-to-back reads by port 0
    for (int i = 0; i < 3; i++) begin
      set0(1'b1, 1'b0, 1'b0, 16'h0300 + 16'(i), 16'h0000);
      step(0);
    end
    set0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(-1);

    // Port 1 locked write; port 0 stalls until port 1 drops lock
    set1(1'b1, 1'b1, 1'b1, 16'h00FF, 16'h1234);
    step(1);
    set0(1'b1, 1'b0, 1'b0, 16'h0400, 16'h0000);
    set1(1'b1, 1'b1, 1'b1, 16'h0401, 16'h1111);
    step(1);
    set1(1'b1, 1'b0, 1'b1, 16'h0402, 16'h0000);
    step(1);
    set1(1'b1, 1'b1, 1'b0, 16'h0403, 16'h2222);
    step(1);
    set1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(0);
    set0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(-1);

    // Port 1 holds lock forever: forced release after 8 owned cycles
    set1(1'b1, 1'b1, 1'b1, 16'h0500, 16'h3333);
    step(1);
    set0(1'b1, 1'b0, 1'b0, 16'h0510, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      set1(1'b1, 1'b0, 1'b1, 16'h0520 + 16'(i), 16'h0000);
      step(1);
    end
    step(0);
    set0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(-1);

    // Reset during OWN0 with a read in flight
    set0(1'b1, 1'b0, 1'b1, 16'h0600, 16'h0000);
    step(0);
    rst_n = 1'b0;
    set0(1'b1, 1'b0, 1'b1, 16'h0601, 16'h0000);
    step(-1);
    rst_n = 1'b1;
    chk("post_reset_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("post_reset_rdata0", {16'd0, rdata0}, 32'd0);
    set0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set1(1'b1, 1'b0, 1'b0, 16'h0700, 16'h0000);
    step(1);
    set1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(-1);
    step(-1);

    chk("gnt_queue_empty", gq.size(), 32'd0);
    chk("rd0_queue_empty", rq0.size(), 32'd0);
    chk("rd1_queue_empty", rq1.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
